pattern_encoder: RTL and testbench

Streams a loaded N-element array out as a sparse sequence of key/value items plus one trailing default item. It produces the same shape as an assignment pattern written with explicit keys and a `default:` entry, such as `'{31:1, 23:1, 15:1, 8:1, default:0}`. It is the read-side counterpart of the team's pattern-based initialisation, used to dump or transmit aggregates compactly. It sits between a producer that holds a whole array and a narrow valid/ready consumer such as a logger or link.

---
 rtl/pattern_encoder_pkg.sv | 17 +
 rtl/pattern_encoder.sv | 184 ++++++++++++++++++
 tb/tb_pattern_encoder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_encoder_pkg.sv
// pattern_encoder_pkg: shared state encoding and default geometry for the
// sparse key/value array encoder.
package pattern_encoder_pkg;

  // Default array geometry: 32 elements of 8 bits.
  localparam int PE_DEFAULT_N = 32;
  localparam int PE_DEFAULT_W = 8;

  // Encoder control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_TAIL = 2'd3
  } pe_state_e;

endpackage : pattern_encoder_pkg

// File: rtl/pattern_encoder.sv
// pattern_encoder: streams a captured N-element array as ascending
// key/value items for every element that differs from the default, then a
// single trailing default item (is_default=1, last=1).
// Optional feature macro: PATTERN_ENCODER_COUNT_EN adds out_count, the number
// of non-default items emitted for the current array.
module pattern_encoder
  import pattern_encoder_pkg::*;
#(
  parameter  int N  = PE_DEFAULT_N,
  parameter  int W  = PE_DEFAULT_W,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic [W-1:0]    in_default,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_key,
  output logic [W-1:0]    out_value,
  output logic            out_is_default,
  output logic            out_last,
`ifdef PATTERN_ENCODER_COUNT_EN
  output logic [IW:0]     out_count,
`endif
  output logic            busy
);

  // One output item; the tail item is assembled from the captured default.
  typedef struct packed {
    logic [IW-1:0] key;
    logic [W-1:0]  value;
    logic          is_default;
    logic          last;
  } pe_item_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  pe_state_e      state_q, state_d;
  logic [IW-1:0]  idx_q,   idx_d;
  logic [N*W-1:0] data_q,  data_d;
  logic [W-1:0]   def_q,   def_d;
  logic [IW-1:0]  key_q,   key_d;
  logic [W-1:0]   val_q,   val_d;
`ifdef PATTERN_ENCODER_COUNT_EN
  logic [IW:0]    cnt_q,   cnt_d;
`endif

  logic [W-1:0]   elem_s;
  logic           at_last_s;
  pe_item_t       item_s;

  assign elem_s    = data_q[idx_q*W +: W];
  assign at_last_s = (idx_q == LAST_IDX);

  // State and datapath registers; reset discards any array in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      def_q   <= '0;
      key_q   <= '0;
      val_q   <= '0;
`ifdef PATTERN_ENCODER_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      def_q   <= def_d;
      key_q   <= key_d;
      val_q   <= val_d;
`ifdef PATTERN_ENCODER_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state: capture on load, scan one element per cycle, emit differing
  // elements in index order, then hand out the default entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    def_d   = def_q;
    key_d   = key_q;
    val_d   = val_q;
`ifdef PATTERN_ENCODER_COUNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          def_d   = in_default;
          idx_d   = '0;
`ifdef PATTERN_ENCODER_COUNT_EN
          cnt_d   = '0;
`endif
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (elem_s != def_q) begin
          key_d   = idx_q;
          val_d   = elem_s;
          state_d = ST_EMIT;
        end else if (at_last_s) begin
          state_d = ST_TAIL;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
`ifdef PATTERN_ENCODER_COUNT_EN
          cnt_d = cnt_q + (IW+1)'(1);
`endif
          if (at_last_s) begin
            state_d = ST_TAIL;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_TAIL: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TAIL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: outputs depend only on registered state, never on inputs.
  always_comb begin
    item_s    = '0;
    out_valid = 1'b0;
    case (state_q)
      ST_EMIT: begin
        out_valid         = 1'b1;
        item_s.key        = key_q;
        item_s.value      = val_q;
        item_s.is_default = 1'b0;
        item_s.last       = 1'b0;
      end
      ST_TAIL: begin
        out_valid         = 1'b1;
        item_s.key        = '0;
        item_s.value      = def_q;
        item_s.is_default = 1'b1;
        item_s.last       = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
        item_s    = '0;
      end
    endcase
  end

  assign in_ready       = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign out_key        = item_s.key;
  assign out_value      = item_s.value;
  assign out_is_default = item_s.is_default;
  assign out_last       = item_s.last;
`ifdef PATTERN_ENCODER_COUNT_EN
  assign out_count      = cnt_q;
`endif

endmodule : pattern_encoder

// File: tb/tb_pattern_encoder.sv
// tb_pattern_encoder: directed self-checking bench for pattern_encoder
// (N=32, W=8).
module tb_pattern_encoder;

  localparam int N = 32;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic [W-1:0]   in_default;
  logic           out_valid;
  logic           out_ready;
  logic [4:0]     out_key;
  logic [W-1:0]   out_value;
  logic           out_is_default;
  logic           out_last;
  logic           busy;
`ifdef PATTERN_ENCODER_COUNT_EN
  logic [5:0]     out_count;
  logic [5:0]     tail_cnt;
`endif

  int n_cmp;
  int n_err;
  int first_lat;

  // Observed items and expected non-default items.
  logic [4:0] kq[$];
  logic [7:0] vq[$];
  logic       dq[$];
  logic       lq[$];
  logic [4:0] ek[$];
  logic [7:0] ev[$];

  pattern_encoder #(.N(N), .W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_default     (in_default),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_key        (out_key),
    .out_value      (out_value),
    .out_is_default (out_is_default),
    .out_last       (out_last),
`ifdef PATTERN_ENCODER_COUNT_EN
    .out_count      (out_count),
`endif
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one array; returns one step after the load edge (first SCAN cycle).
  task automatic load(input logic [N*W-1:0] d, input logic [7:0] df);
    int w;
    w = 0;
    while (!in_ready && w < 500) begin
      tick();
      w++;
    end
    if (!in_ready) check("load_wait_timeout", 64'(0), 64'(1));
    in_data    = d;
    in_default = df;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  // Gather items until the tail handshake completes; checks hold-under-backpressure.
  task automatic collect(input bit rand_ready);
    int  cyc;
    bit  r;
    bit  hold;
    bit  done;
    bit  seen;
    logic [4:0] hk;
    logic [7:0] hv;
    kq.delete(); vq.delete(); dq.delete(); lq.delete();
    cyc = 0; hold = 1'b0; done = 1'b0; seen = 1'b0; first_lat = -1;
    while (!done && cyc < 3000) begin
      check("in_ready_while_busy", 64'(in_ready), 64'(0));
      if (hold) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_key",   64'(out_key),   64'(hk));
        check("hold_value", 64'(out_value), 64'(hv));
      end
      if (out_valid && !seen) begin
        seen = 1'b1;
        first_lat = cyc;
      end
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (out_valid) begin
        if (r) begin
          kq.push_back(out_key);
          vq.push_back(out_value);
          dq.push_back(out_is_default);
          lq.push_back(out_last);
          hold = 1'b0;
`ifdef PATTERN_ENCODER_COUNT_EN
          if (out_last) tail_cnt = out_count;
`endif
          if (out_last) done = 1'b1;
        end else begin
          hold = 1'b1;
          hk   = out_key;
          hv   = out_value;
        end
      end
      tick();
      cyc++;
    end
    if (!done) check("collect_timeout", 64'(0), 64'(1));
    out_ready = 1'b0;
  endtask

  // Compare gathered items against ek/ev followed by the default tail.
  task automatic check_items(input logic [7:0] def);
    int n;
    check("item_count", 64'(kq.size()), 64'(ek.size() + 1));
    n = (kq.size() < ek.size()) ? kq.size() : ek.size();
    for (int i = 0; i < n; i++) begin
      check("item_key",   64'(kq[i]), 64'(ek[i]));
      check("item_value", 64'(vq[i]), 64'(ev[i]));
      check("item_isdef", 64'(dq[i]), 64'(0));
      check("item_last",  64'(lq[i]), 64'(0));
    end
    if (kq.size() > 0) begin
      check("tail_key",   64'(kq[kq.size()-1]), 64'(0));
      check("tail_value", 64'(vq[vq.size()-1]), 64'(def));
      check("tail_isdef", 64'(dq[dq.size()-1]), 64'(1));
      check("tail_last",  64'(lq[lq.size()-1]), 64'(1));
    end
  endtask

  task automatic set_sparse_expect();
    ek.delete(); ev.delete();
    ek.push_back(5'd8);  ev.push_back(8'd1);
    ek.push_back(5'd15); ev.push_back(8'd1);
    ek.push_back(5'd23); ev.push_back(8'd1);
    ek.push_back(5'd31); ev.push_back(8'd1);
  endtask

  logic [N*W-1:0] sparse_d;
  logic [N*W-1:0] flat_d;
  logic [N*W-1:0] inc_d;
  logic [N*W-1:0] a_d;
  logic [N*W-1:0] b_d;

  initial begin
    int w;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_default = 8'h00;

    sparse_d = '0;
    sparse_d[8*8 +: 8]  = 8'd1;
    sparse_d[15*8 +: 8] = 8'd1;
    sparse_d[23*8 +: 8] = 8'd1;
    sparse_d[31*8 +: 8] = 8'd1;
    for (int k = 0; k < N; k++) begin
      flat_d[k*8 +: 8] = 8'h5A;
      inc_d[k*8 +: 8]  = 8'(k + 1);
      a_d[k*8 +: 8]    = 8'h11;
    end
    a_d[3*8 +: 8]  = 8'h07;
    a_d[20*8 +: 8] = 8'h33;
    b_d = '0;
    b_d[5*8 +: 8] = 8'h44;

    // Reset values.
    #12;
    check("rst_in_ready",  64'(in_ready),       64'(1));
    check("rst_out_valid", 64'(out_valid),      64'(0));
    check("rst_busy",      64'(busy),           64'(0));
    check("rst_isdef",     64'(out_is_default), 64'(0));
    check("rst_last",      64'(out_last),       64'(0));
    check("rst_key",       64'(out_key),        64'(0));
    check("rst_value",     64'(out_value),      64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Sparse array, consumer always ready: first item 9 cycles after SCAN entry.
    load(sparse_d, 8'h00);
    collect(1'b0);
    check("sparse_latency", 64'(first_lat), 64'(9));
    set_sparse_expect();
    check_items(8'h00);
`ifdef PATTERN_ENCODER_COUNT_EN
    check("sparse_count", 64'(tail_cnt), 64'(4));
`endif
    tick();

    // All elements equal to the default: only the tail, after 32 SCAN cycles.
    load(flat_d, 8'h5A);
    collect(1'b0);
    check("flat_latency", 64'(first_lat), 64'(32));
    ek.delete(); ev.delete();
    check_items(8'h5A);
    tick();

    // Every element differs: keys 0..31, values 1..32, then the tail.
    load(inc_d, 8'h00);
    collect(1'b0);
    check("inc_latency", 64'(first_lat), 64'(1));
    ek.delete(); ev.delete();
    for (int k = 0; k < N; k++) begin
      ek.push_back(5'(k));
      ev.push_back(8'(k + 1));
    end
    check_items(8'h00);
`ifdef PATTERN_ENCODER_COUNT_EN
    check("inc_count", 64'(tail_cnt), 64'(32));
`endif
    tick();

    // Sparse array under random backpressure.
    load(sparse_d, 8'h00);
    collect(1'b1);
    set_sparse_expect();
    check_items(8'h00);
    tick();

    // Reset while the key-8 item is being held by backpressure.
    load(sparse_d, 8'h00);
    out_ready = 1'b0;
    w = 0;
    while (!out_valid && w < 200) begin
      tick();
      w++;
    end
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    check("pre_rst_key",   64'(out_key),   64'(8));
    rst = 1'b1;
    #1;
    check("mid_rst_valid",    64'(out_valid), 64'(0));
    check("mid_rst_key",      64'(out_key),   64'(0));
    check("mid_rst_value",    64'(out_value), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready),  64'(1));
    check("mid_rst_busy",     64'(busy),      64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    load(sparse_d, 8'h00);
    collect(1'b0);
    check("post_rst_latency", 64'(first_lat), 64'(9));
    set_sparse_expect();
    check_items(8'h00);
    tick();

    // in_valid held high: second array waits for one IDLE cycle, no mixing.
    in_data = a_d; in_default = 8'h11; in_valid = 1'b1;
    tick();
    in_data = b_d; in_default = 8'h00;
    check("held_busy", 64'(busy), 64'(1));
    collect(1'b0);
    ek.delete(); ev.delete();
    ek.push_back(5'd3);  ev.push_back(8'h07);
    ek.push_back(5'd20); ev.push_back(8'h33);
    check_items(8'h11);
    check("held_idle_in_ready", 64'(in_ready), 64'(1));
    check("held_idle_busy",     64'(busy),     64'(0));
    tick();
    in_valid = 1'b0;
    check("held_second_busy", 64'(busy), 64'(1));
    collect(1'b0);
    ek.delete(); ev.delete();
    ek.push_back(5'd5); ev.push_back(8'h44);
    check_items(8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pattern_encoder
